// File: rtl/ee446_datapath_pkg.sv
// Shared datapath constants for the multi-cycle processor: register-file
// address width, register count and the special PC/LR register indices.
package ee446_datapath_pkg;

   localparam int REG_ADDR_W = 4;
   localparam int REG_COUNT  = 16;

   localparam logic [REG_ADDR_W-1:0] PC_IDX = 4'd15;
   localparam logic [REG_ADDR_W-1:0] LR_IDX = 4'd14;

endpackage

// File: rtl/register_file_if.sv
// Register-file access bundle: two read ports, the general write port,
// the link-register write port and the externally supplied PC+8 value.
interface register_file_if
   import ee446_datapath_pkg::*;
#(
   parameter int W = 32
) ();

   logic [REG_ADDR_W-1:0] a1;
   logic [REG_ADDR_W-1:0] a2;
   logic [REG_ADDR_W-1:0] a3;
   logic                  we3;
   logic [W-1:0]          wd3;
   logic                  link_we;
   logic [W-1:0]          link_data;
   logic [W-1:0]          r15;
   logic [W-1:0]          rd1;
   logic [W-1:0]          rd2;

   modport master (
      output a1, a2, a3, we3, wd3, link_we, link_data, r15,
      input  rd1, rd2
   );

   modport slave (
      input  a1, a2, a3, we3, wd3, link_we, link_data, r15,
      output rd1, rd2
   );

endinterface

// File: rtl/register_file_wr_decoder.sv
// Write-port decoder: per-register write enables for R0-R14 and the source
// select (wd3 or link_data). R15 is never written; the link port owns R14.
module regfile_wr_decoder
   import ee446_datapath_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] a3,
   input  logic                  we3,
   input  logic                  link_we,
   output logic [REG_COUNT-2:0]  wr_en,
   output logic [REG_COUNT-2:0]  src_link
);

   // The loop stops at R14, so a3 = 15 simply matches nothing.
   always_comb begin
      wr_en    = '0;
      src_link = '0;
      for (int i = 0; i < REG_COUNT - 1; i++) begin
         if (we3 && (a3 == REG_ADDR_W'(i))) begin
            wr_en[i] = 1'b1;
         end
      end
      if (link_we) begin
         wr_en[LR_IDX]    = 1'b1;
         src_link[LR_IDX] = 1'b1;
      end
   end

endmodule

// File: rtl/register_file.sv
// Sixteen-entry register file (R15 reads back PC+8) with one general and one
// link write port. Define REGFILE_BYPASS_EN for same-cycle write-through reads.
module register_file
   import ee446_datapath_pkg::*;
#(
   parameter int W = 32
) (
   input  logic            clk,
   input  logic            rst,
   register_file_if.slave  bus
);

   logic [W-1:0]         regs_q [REG_COUNT-1];
   logic [W-1:0]         regs_d [REG_COUNT-1];
   logic [REG_COUNT-2:0] wr_en;
   logic [REG_COUNT-2:0] src_link;
   logic [W-1:0]         rd1_v;
   logic [W-1:0]         rd2_v;

   regfile_wr_decoder u_wr_decoder (
      .a3       (bus.a3),
      .we3      (bus.we3),
      .link_we  (bus.link_we),
      .wr_en    (wr_en),
      .src_link (src_link)
   );

   always_comb begin
      for (int i = 0; i < REG_COUNT - 1; i++) begin
         regs_d[i] = regs_q[i];
         if (wr_en[i]) begin
            regs_d[i] = src_link[i] ? bus.link_data : bus.wd3;
         end
      end
   end

   // Reset outranks both write ports, dropping any write in that cycle.
   always_ff @(posedge clk) begin
      for (int i = 0; i < REG_COUNT - 1; i++) begin
         if (rst) begin
            regs_q[i] <= '0;
         end else begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   always_comb begin
      rd1_v = bus.r15;
      rd2_v = bus.r15;
      for (int i = 0; i < REG_COUNT - 1; i++) begin
         if (bus.a1 == REG_ADDR_W'(i)) rd1_v = regs_q[i];
         if (bus.a2 == REG_ADDR_W'(i)) rd2_v = regs_q[i];
      end
`ifdef REGFILE_BYPASS_EN
      // Link data is checked last so it overrides wd3, matching write priority.
      if (!rst && (bus.a1 != PC_IDX)) begin
         if (bus.we3 && (bus.a1 == bus.a3)) rd1_v = bus.wd3;
         if (bus.link_we && (bus.a1 == LR_IDX)) rd1_v = bus.link_data;
      end
      if (!rst && (bus.a2 != PC_IDX)) begin
         if (bus.we3 && (bus.a2 == bus.a3)) rd2_v = bus.wd3;
         if (bus.link_we && (bus.a2 == LR_IDX)) rd2_v = bus.link_data;
      end
`endif
   end

   assign bus.rd1 = rd1_v;
   assign bus.rd2 = rd2_v;

endmodule
